// File: rtl/frame_top2_pkg.sv
// Shared types and helpers for the frame-level top-2 tracker controller.
package frame_top2_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    // Beat counter must hold the value MAX_FRAME_LEN itself.
    function automatic int unsigned cnt_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/top2_tracker.sv
// Running largest / second-largest tracker over unsigned samples.
// clr has priority over en; clr together with en loads (din, 0).
module top2_tracker #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] largest,
    output logic [DATA_WIDTH-1:0] second
);

    logic [DATA_WIDTH-1:0] largest_q, largest_d;
    logic [DATA_WIDTH-1:0] second_q, second_d;

    always_comb begin
        largest_d = largest_q;
        second_d  = second_q;
        if (clr) begin
            largest_d = en ? din : '0;
            second_d  = '0;
        end else if (en) begin
            // A duplicate of the current largest falls through to second.
            if (din > largest_q) begin
                largest_d = din;
                second_d  = largest_q;
            end else if (din > second_q) begin
                second_d = din;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            largest_q <= '0;
            second_q  <= '0;
        end else begin
            largest_q <= largest_d;
            second_q  <= second_d;
        end
    end

    assign largest = largest_q;
    assign second  = second_q;

endmodule

// File: rtl/frame_top2_ctrl.sv
// Frame controller around top2_tracker: frames a valid/ready sample stream, holds the result.
// Define FRAME_TOP2_INDEX_EN to add out_largest_idx (beat index of the final largest).
module frame_top2_ctrl
    import frame_top2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MAX_FRAME_LEN = 256,
    localparam int unsigned CNT_W        = cnt_width(MAX_FRAME_LEN)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_largest,
    output logic [DATA_WIDTH-1:0] out_second,
    output logic [CNT_W-1:0]      out_count,
`ifdef FRAME_TOP2_INDEX_EN
    output logic [CNT_W-1:0]      out_largest_idx,
`endif
    output logic                  out_overflow
);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d, count_inc;
    logic                  overflow_q, overflow_d;
    logic                  accept, at_max, close, capture;
    logic [DATA_WIDTH-1:0] trk_largest, trk_second;
    logic [DATA_WIDTH-1:0] res_largest_q, res_second_q;
    logic [CNT_W-1:0]      res_count_q;
    logic                  show_live;

    assign in_ready  = (state_q != S_RESULT);
    assign accept    = in_valid && in_ready;
    assign count_inc = (state_q == S_IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
    assign at_max    = (count_inc == CNT_W'(MAX_FRAME_LEN));
    assign close     = accept && (in_last || at_max);

    top2_tracker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tracker (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (accept && (state_q == S_IDLE)),
        .en      (accept),
        .din     (in_data),
        .largest (trk_largest),
        .second  (trk_second)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        capture    = 1'b0;
        unique case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    count_d = count_inc;
                    state_d = S_ACCUM;
                    if (close) begin
                        state_d    = S_RESULT;
                        overflow_d = !in_last;
                    end
                end
            end
            S_RESULT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    capture = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Tracker is frozen in S_RESULT; snapshot it at the handshake so outputs
    // keep their values once the next frame starts reloading the tracker.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_largest_q <= '0;
            res_second_q  <= '0;
            res_count_q   <= '0;
        end else if (capture) begin
            res_largest_q <= trk_largest;
            res_second_q  <= trk_second;
            res_count_q   <= count_q;
        end
    end

    assign show_live    = (state_q == S_RESULT);
    assign out_valid    = show_live;
    assign out_largest  = show_live ? trk_largest : res_largest_q;
    assign out_second   = show_live ? trk_second  : res_second_q;
    assign out_count    = show_live ? count_q     : res_count_q;
    assign out_overflow = overflow_q;

`ifdef FRAME_TOP2_INDEX_EN
    logic [CNT_W-1:0] idx_q, idx_d, res_idx_q;

    always_comb begin
        idx_d = idx_q;
        if (accept && (state_q == S_IDLE)) begin
            idx_d = '0;
        end else if (accept && (in_data > trk_largest)) begin
            idx_d = count_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q     <= '0;
            res_idx_q <= '0;
        end else begin
            idx_q <= idx_d;
            if (capture) begin
                res_idx_q <= idx_q;
            end
        end
    end

    assign out_largest_idx = show_live ? idx_q : res_idx_q;
`endif

endmodule
